syn_i2c_cfg_seq: RTL and testbench

SYN_I2C_CFG_SEQ -- requirements
Module: syn_i2c_cfg_seq

---
 rtl/syn_acortex_reg_map.sv | 7 +
 rtl/syn_global_pkg.sv | 15 +
 rtl/syn_i2c_cfg_seq_if.sv | 20 ++
 rtl/syn_i2c_cfg_rom.sv | 18 +
 rtl/syn_i2c_cfg_seq.sv | 209 ++++++++++++++++++++
 tb/tb_syn_i2c_cfg_seq.sv | 251 +++++++++++++++++++++++++
 6 files changed

// File: rtl/syn_acortex_reg_map.sv
// Local-bus register addresses of the Acortex I2C master.
package syn_acortex_reg_map;
  localparam logic [7:0] REG_CLK_DIV = 8'h00;
  localparam logic [7:0] REG_ADDR    = 8'h04;
  localparam logic [7:0] REG_DATA    = 8'h08;
  localparam logic [7:0] REG_STATUS  = 8'h0C;
endpackage

// File: rtl/syn_global_pkg.sv
// Shared types for the codec configuration sequencer: FSM states, table entries, default WM8731 table.
package syn_global_pkg;
  typedef enum logic [3:0] {
    IDLE, WR_DIV, WR_ADDR, WR_DATA, WR_GO, GAP, RD_STAT, CHECK, DONE, ERR
  } cfg_state_e;

  // {7-bit codec register, 9-bit value}
  typedef logic [15:0] cfg_entry_t;

  localparam int CFG_TABLE_LEN = 11;
  localparam cfg_entry_t CFG_TABLE [CFG_TABLE_LEN] = '{
    16'h1E00, 16'h0C00, 16'h0E42, 16'h1000, 16'h1201, 16'h0017,
    16'h0217, 16'h0479, 16'h0679, 16'h0812, 16'h0A00
  };
endpackage

// File: rtl/syn_i2c_cfg_seq_if.sv
// Local bus between the configuration sequencer (master) and the I2C master block (slave).
interface syn_i2c_cfg_seq_if;
  logic        i2cm_wr_en;
  logic        i2cm_rd_en;
  logic [7:0]  i2cm_addr;
  logic [15:0] i2cm_wr_data;
  logic        i2cm_wr_valid;
  logic        i2cm_rd_valid;
  logic [15:0] i2cm_rd_data;

  modport master (
    output i2cm_wr_en, i2cm_rd_en, i2cm_addr, i2cm_wr_data,
    input  i2cm_wr_valid, i2cm_rd_valid, i2cm_rd_data
  );

  modport slave (
    input  i2cm_wr_en, i2cm_rd_en, i2cm_addr, i2cm_wr_data,
    output i2cm_wr_valid, i2cm_rd_valid, i2cm_rd_data
  );
endinterface

// File: rtl/syn_i2c_cfg_rom.sv
// Combinational lookup of the codec table; indices past the table read as zero.
module syn_i2c_cfg_rom
  import syn_global_pkg::*;
#(
  parameter int P_NUM_REGS = 11
) (
  input  logic [3:0] idx_i,
  output cfg_entry_t entry_o
);

  always_comb begin
    entry_o = '0;
    for (int i = 0; i < CFG_TABLE_LEN; i++) begin
      if (i < P_NUM_REGS && idx_i == 4'(i)) entry_o = CFG_TABLE[i];
    end
  end

endmodule

// File: rtl/syn_i2c_cfg_seq.sv
// Writes the WM8731 table through the I2C master local bus, one strobe outstanding at a time.
// Build option SYN_I2C_CFG_RETRY_EN re-sends a NACKed entry up to P_MAX_RETRY times before ERR.
module syn_i2c_cfg_seq
  import syn_global_pkg::*;
  import syn_acortex_reg_map::*;
#(
  parameter logic [7:0] P_DEV_ADDR  = 8'h34,
  parameter int         P_NUM_REGS  = 11,
  parameter logic [7:0] P_CLK_DIV   = 8'd249,
  parameter int         P_POLL_GAP  = 16,
  parameter int         P_MAX_RETRY = 3
) (
  input  logic              clk_ir,
  input  logic              rst_sync,
  input  logic              cfg_start,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic [3:0]        cfg_err_idx,
  syn_i2c_cfg_seq_if.master i2cm
);

  localparam int               GAP_W    = $clog2(P_POLL_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(P_POLL_GAP - 1);
  localparam logic [3:0]       LAST_IDX = 4'(P_NUM_REGS - 1);

  cfg_state_e       state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [1:0]       stat_q, stat_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [3:0]       err_idx_q, err_idx_d;
  logic             wr_en_q, wr_en_d;
  logic             rd_en_q, rd_en_d;
  logic [7:0]       addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic             retry_clr, retry_inc, retry_ok;
  cfg_entry_t       rom_entry;
  logic             rd_data_unused;

  syn_i2c_cfg_rom #(.P_NUM_REGS(P_NUM_REGS)) u_rom (
    .idx_i   (idx_q),
    .entry_o (rom_entry)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    stat_d    = stat_q;
    done_d    = done_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    retry_clr = 1'b0;
    retry_inc = 1'b0;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (cfg_start) begin
          state_d   = WR_DIV;
          done_d    = 1'b0;
          err_d     = 1'b0;
          err_idx_d = '0;
          idx_d     = '0;
          retry_clr = 1'b1;
        end
      end
      WR_DIV:  if (i2cm.i2cm_wr_valid) state_d = WR_ADDR;
      WR_ADDR: if (i2cm.i2cm_wr_valid) state_d = WR_DATA;
      WR_DATA: if (i2cm.i2cm_wr_valid) state_d = WR_GO;
      WR_GO: begin
        if (i2cm.i2cm_wr_valid) begin
          state_d = GAP;
          gap_d   = '0;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = RD_STAT;
        else                   gap_d   = gap_q + 1'b1;
      end
      RD_STAT: begin
        if (i2cm.i2cm_rd_valid) begin
          stat_d  = i2cm.i2cm_rd_data[1:0];
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (stat_q[0]) begin
          state_d = GAP;
          gap_d   = '0;
        end else if (!stat_q[1]) begin
          retry_clr = 1'b1;
          idx_d     = (idx_q == 4'hF) ? idx_q : idx_q + 4'd1;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = WR_ADDR;
          end
        end else if (retry_ok) begin
          retry_inc = 1'b1;
          state_d   = WR_ADDR;
        end else begin
          state_d   = ERR;
          err_d     = 1'b1;
          err_idx_d = idx_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every bus access is launched on the edge that enters its state.
    if (state_d != state_q) begin
      case (state_d)
        WR_DIV: begin
          wr_en_d = 1'b1;
          addr_d  = REG_CLK_DIV;
          wdata_d = {8'h00, P_CLK_DIV};
        end
        WR_ADDR: begin
          wr_en_d = 1'b1;
          addr_d  = REG_ADDR;
          wdata_d = {8'h00, P_DEV_ADDR};
        end
        WR_DATA: begin
          wr_en_d = 1'b1;
          addr_d  = REG_DATA;
          wdata_d = rom_entry;
        end
        WR_GO: begin
          wr_en_d = 1'b1;
          addr_d  = REG_STATUS;
          wdata_d = 16'h0000;
        end
        RD_STAT: begin
          rd_en_d = 1'b1;
          addr_d  = REG_STATUS;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_ir or posedge rst_sync) begin
    if (rst_sync) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      gap_q     <= '0;
      stat_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      stat_q    <= stat_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

`ifdef SYN_I2C_CFG_RETRY_EN
  localparam int RETRY_W = $clog2(P_MAX_RETRY + 1);
  logic [RETRY_W-1:0] retry_q, retry_d;

  always_comb begin
    retry_d = retry_q;
    if (retry_clr)                          retry_d = '0;
    else if (retry_inc && retry_q != '1)    retry_d = retry_q + 1'b1;
  end

  always_ff @(posedge clk_ir or posedge rst_sync) begin
    if (rst_sync) retry_q <= '0;
    else          retry_q <= retry_d;
  end

  assign retry_ok = (retry_q < RETRY_W'(P_MAX_RETRY));
`else
  logic retry_unused;
  assign retry_ok     = 1'b0;
  assign retry_unused = retry_clr | retry_inc | (P_MAX_RETRY != 0);
`endif

  assign rd_data_unused     = ^i2cm.i2cm_rd_data[15:2];
  assign cfg_busy           = !(state_q == IDLE || state_q == DONE || state_q == ERR);
  assign cfg_done           = done_q;
  assign cfg_err            = err_q;
  assign cfg_err_idx        = err_idx_q;
  assign i2cm.i2cm_wr_en    = wr_en_q;
  assign i2cm.i2cm_rd_en    = rd_en_q;
  assign i2cm.i2cm_addr     = addr_q;
  assign i2cm.i2cm_wr_data  = wdata_q;

endmodule

// File: tb/tb_syn_i2c_cfg_seq.sv
// Bench for syn_i2c_cfg_seq: scenario table against a behavioural I2C master, plus reset/restart corner cases.
module tb_syn_i2c_cfg_seq;
  import syn_acortex_reg_map::*;

  localparam int NUM_REGS = 11;
`ifdef SYN_I2C_CFG_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif
  localparam int MAX_ATT = RETRY ? 4 : 1;
  localparam int BUDGET  = 4000;
  localparam logic [15:0] TB_TABLE [NUM_REGS] = '{
    16'h1E00, 16'h0C00, 16'h0E42, 16'h1000, 16'h1201, 16'h0017,
    16'h0217, 16'h0479, 16'h0679, 16'h0812, 16'h0A00
  };

  typedef struct {
    string name;
    int    ne;      // entry the slave NACKs
    int    nt;      // how many times it NACKs it
    int    wdly;    // write-acknowledge delay
    int    go;      // expected STATUS writes
    bit    done;
    bit    err;
    int    eidx;
  } vec_t;

  logic       clk_ir = 1'b0;
  logic       rst_sync = 1'b1;
  logic       cfg_start = 1'b0;
  logic       cfg_busy, cfg_done, cfg_err;
  logic [3:0] cfg_err_idx;

  syn_i2c_cfg_seq_if bus();

  syn_i2c_cfg_seq dut (
    .clk_ir      (clk_ir),
    .rst_sync    (rst_sync),
    .cfg_start   (cfg_start),
    .cfg_busy    (cfg_busy),
    .cfg_done    (cfg_done),
    .cfg_err     (cfg_err),
    .cfg_err_idx (cfg_err_idx),
    .i2cm        (bus)
  );

  always #5 clk_ir = ~clk_ir;

  int checks = 0, failures = 0;
  int wdly = 1, nack_ent = 15, nack_times = 0, nack_given = 0, ent = 0;
  int wcnt = 0, rcnt = 0, busy_cnt = 0;
  int proto_err = 0, go_cnt = 0, rst_strobes = 0;
  bit nack_flag = 0, outstanding = 0, prev_wr = 0, prev_rd = 0;
  logic [7:0]  cap_addr;
  logic [15:0] cap_data;
  logic [7:0]  log_addr[$];
  logic [15:0] log_data[$];

  // Behavioural I2C master plus bus-protocol monitor, evaluated on the falling edge.
  always @(negedge clk_ir) begin
    if (rst_sync) begin
      if (bus.i2cm_wr_en || bus.i2cm_rd_en) rst_strobes++;
      bus.i2cm_wr_valid = 1'b0;
      bus.i2cm_rd_valid = 1'b0;
      bus.i2cm_rd_data  = 16'h0;
      wcnt = 0; rcnt = 0; busy_cnt = 0; ent = 0;
      nack_flag = 0; outstanding = 0; prev_wr = 0; prev_rd = 0;
    end else begin
      if ((bus.i2cm_wr_en || bus.i2cm_rd_en) && outstanding) proto_err++;
      if ((bus.i2cm_wr_en && prev_wr) || (bus.i2cm_rd_en && prev_rd)) proto_err++;
      if (outstanding && (bus.i2cm_addr !== cap_addr || bus.i2cm_wr_data !== cap_data)) proto_err++;
      prev_wr = bus.i2cm_wr_en;
      prev_rd = bus.i2cm_rd_en;
      bus.i2cm_wr_valid = 1'b0;
      bus.i2cm_rd_valid = 1'b0;
      if (busy_cnt > 0) busy_cnt--;
      if (wcnt > 0) begin
        wcnt--;
        if (wcnt == 0) begin bus.i2cm_wr_valid = 1'b1; outstanding = 0; end
      end
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin
          bus.i2cm_rd_valid = 1'b1;
          outstanding = 0;
          bus.i2cm_rd_data = {14'h0, (busy_cnt == 0) && nack_flag, busy_cnt != 0};
          if (busy_cnt == 0 && !nack_flag) ent++;
        end
      end
      if (bus.i2cm_wr_en) begin
        outstanding = 1; cap_addr = bus.i2cm_addr; cap_data = bus.i2cm_wr_data;
        wcnt = wdly;
        log_addr.push_back(bus.i2cm_addr);
        log_data.push_back(bus.i2cm_wr_data);
        if (bus.i2cm_addr == REG_STATUS) begin
          go_cnt++;
          busy_cnt = 40;
          if (ent == nack_ent && nack_given < nack_times) begin
            nack_flag = 1; nack_given++;
          end else begin
            nack_flag = 0;
          end
        end
      end
      if (bus.i2cm_rd_en) begin
        outstanding = 1; cap_addr = bus.i2cm_addr; cap_data = bus.i2cm_wr_data;
        rcnt = 1;
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic setup(input int ne, input int nt, input int dly);
    nack_ent = ne; nack_times = nt; nack_given = 0; wdly = dly; ent = 0;
    go_cnt = 0; proto_err = 0;
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic start_pass();
    @(negedge clk_ir) cfg_start = 1'b1;
    @(negedge clk_ir) cfg_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (cfg_busy && n < BUDGET) begin
      @(negedge clk_ir);
      n++;
    end
    check({name, ".timeout"}, longint'(n >= BUDGET), 0);
  endtask

  task automatic check_writes(input string name, input int ne, input int nt);
    logic [7:0]  ea[$];
    logic [15:0] ed[$];
    int mis, att;
    bit stop;
    mis = 0; stop = 0;
    ea.push_back(REG_CLK_DIV); ed.push_back(16'd249);
    for (int e = 0; e < NUM_REGS && !stop; e++) begin
      att = 1;
      if (e == ne) begin
        att  = (nt + 1 < MAX_ATT) ? nt + 1 : MAX_ATT;
        stop = (nt >= MAX_ATT);
      end
      for (int a = 0; a < att; a++) begin
        ea.push_back(REG_ADDR);   ed.push_back(16'h0034);
        ea.push_back(REG_DATA);   ed.push_back(TB_TABLE[e]);
        ea.push_back(REG_STATUS); ed.push_back(16'h0000);
      end
    end
    check({name, ".nwrites"}, log_addr.size(), ea.size());
    for (int i = 0; i < ea.size() && i < log_addr.size(); i++)
      if (log_addr[i] !== ea[i] || log_data[i] !== ed[i]) mis++;
    check({name, ".wseq_mismatches"}, mis, 0);
  endtask

  initial begin
    vec_t vecs[5];
    int n;
    vecs[0] = '{"nominal",   15, 0,  1, 11, 1'b1, 1'b0, 0};
    vecs[1] = '{"nack4_pers", 4, 99, 1, RETRY ? 8 : 5, 1'b0, 1'b1, 4};
    vecs[2] = '{"slow_wr",   15, 0,  7, 11, 1'b1, 1'b0, 0};
    vecs[3] = '{"nack2_once", 2, 1,  1, RETRY ? 12 : 3, RETRY, !RETRY, RETRY ? 0 : 2};
    vecs[4] = '{"nack9_twice", 9, 2, 3, RETRY ? 13 : 10, RETRY, !RETRY, RETRY ? 0 : 9};

    repeat (3) @(negedge clk_ir);
    check("rst.busy",    cfg_busy, 0);
    check("rst.done",    cfg_done, 0);
    check("rst.err",     cfg_err, 0);
    check("rst.err_idx", cfg_err_idx, 0);
    check("rst.wr_en",   bus.i2cm_wr_en, 0);
    check("rst.rd_en",   bus.i2cm_rd_en, 0);
    check("rst.addr",    bus.i2cm_addr, 0);
    check("rst.wr_data", bus.i2cm_wr_data, 0);
    rst_sync = 1'b0;
    setup(15, 0, 1);
    repeat (6) @(negedge clk_ir);
    check("idle.no_autostart", log_addr.size(), 0);

    for (int v = 0; v < 5; v++) begin
      setup(vecs[v].ne, vecs[v].nt, vecs[v].wdly);
      start_pass();
      wait_idle(vecs[v].name);
      check({vecs[v].name, ".busy"},    cfg_busy, 0);
      check({vecs[v].name, ".done"},    cfg_done, vecs[v].done);
      check({vecs[v].name, ".err"},     cfg_err, vecs[v].err);
      check({vecs[v].name, ".err_idx"}, cfg_err_idx, vecs[v].eidx);
      check({vecs[v].name, ".go_cnt"},  go_cnt, vecs[v].go);
      check({vecs[v].name, ".proto"},   proto_err, 0);
      check_writes(vecs[v].name, vecs[v].ne, vecs[v].nt);
    end

    // cfg_start while a status read is outstanding must be ignored
    setup(15, 0, 1);
    start_pass();
    n = 0;
    while (!bus.i2cm_rd_en && n < BUDGET) begin @(negedge clk_ir); n++; end
    check("rdstat.reached", bus.i2cm_rd_en, 1);
    cfg_start = 1'b1;
    @(negedge clk_ir) cfg_start = 1'b0;
    wait_idle("rdstat");
    check("rdstat.done",   cfg_done, 1);
    check("rdstat.go_cnt", go_cnt, 11);
    check("rdstat.proto",  proto_err, 0);
    check_writes("rdstat", 15, 0);

    // asynchronous reset during the poll gap of entry 5, then a clean restart
    setup(15, 0, 1);
    start_pass();
    n = 0;
    while (go_cnt < 6 && n < BUDGET) begin @(negedge clk_ir); n++; end
    repeat (8) @(negedge clk_ir);
    check("gap5.busy_before", cfg_busy, 1);
    check("gap5.addr_before", bus.i2cm_addr, REG_STATUS);
    rst_strobes = 0;
    #2 rst_sync = 1'b1;
    #1;
    check("gap5.rst_busy",    cfg_busy, 0);
    check("gap5.rst_wr_en",   bus.i2cm_wr_en, 0);
    check("gap5.rst_rd_en",   bus.i2cm_rd_en, 0);
    check("gap5.rst_addr",    bus.i2cm_addr, 0);
    check("gap5.rst_wr_data", bus.i2cm_wr_data, 0);
    check("gap5.rst_done",    cfg_done, 0);
    repeat (3) @(negedge clk_ir);
    check("gap5.rst_strobes", rst_strobes, 0);
    rst_sync = 1'b0;
    setup(15, 0, 1);
    start_pass();
    wait_idle("restart");
    check("restart.first_addr", (log_addr.size() > 0) ? log_addr[0] : 8'hFF, REG_CLK_DIV);
    check("restart.first_data", (log_data.size() > 0) ? log_data[0] : 16'hFFFF, 249);
    check("restart.done",   cfg_done, 1);
    check("restart.go_cnt", go_cnt, 11);
    check_writes("restart", 15, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
